alu_serial_ctrl: RTL and testbench
==================================

# alu_serial_ctrl

Bit-serial ALU controller. It accepts a full-width operation and operands, then issues the 4-bit ALU op to a 1-bit ALU slice one bit per clock, LSB first. It threads the slice's carry-out back into its carry-in and assembles the result word with flags. It sits between the datapath register file and a single 1-bit ALU slice, trading WIDTH cycles of latency for one slice of logic.

## Interface
- `WIDTH`, default 32: operand and result width, ≥ 2.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: request a new operation. Sampled only in IDLE or DONE.
- `op`, input, 4: ALU op.
  - bit3 = invert A.
  - bit2 = invert B, and carry-in 1.
  - bits1:0 select the function: 00 AND, 01 OR, 10 ADD, 11 reserved.
- `a`, input, WIDTH: operand A, sampled with `start`.
- `b`, input, WIDTH: operand B, sampled with `start`.
- `busy`, output, 1: operation in progress (state RUN).
- `done`, output, 1: one-cycle pulse; result and flags valid from this cycle.
- `result`, output, WIDTH: registered result, held until the next `done`.
- `zero`, output, 1: `result == 0`, held with `result`.
- `carry_out`, output, 1: carry out of the MSB for ADD-class ops; 0 for logic ops.
- `overflow`, output, 1: signed overflow for ADD-class ops (carry into MSB XOR carry out of MSB); 0 for logic ops.

## Operation
- States:
  - IDLE: `start` → RUN.
  - RUN: count == WIDTH-1 → DONE; otherwise stay in RUN.
  - DONE: `start` → RUN; otherwise → IDLE.
- On accept (start in IDLE or DONE):
  - Latch `a`, `b` and `op` into internal shift registers.
  - Set `count` = 0.
  - Set the carry register to `op[2]`.
- RUN, each cycle:
  - Present `a_sh[0]`, `b_sh[0]`, the carry register and the latched op to the slice.
  - Shift the slice result bit into the MSB of the result shift register, then shift `a_sh`/`b_sh` right.
  - For ADD-class ops, load the carry register from slice carry-out.
  - Increment `count`.
- Slice function:
  - a' = a ^ op[3], b' = b ^ op[2].
  - AND → a'&b'.
  - OR → a'|b'.
  - ADD → a'^b'^cin, with cout = majority(a', b', cin).
  - Reserved (11) → result bit 0.
  - cout = 0 for every non-ADD op.
- Named ops: AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100.
- On entry to DONE, update the outputs:
  - `result` = assembled word.
  - `zero` = (result == 0).
  - `carry_out` = final carry, for ADD-class ops only.
  - `overflow` = carry-in at bit WIDTH-1 XOR final carry, for ADD-class ops only.
  - A reserved op yields result 0 and zero 1.
- Any `start` while in RUN is ignored; no queueing.
- `op`, `a` and `b` changes during RUN have no effect.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `result` 0, `zero` 0, `carry_out` 0, `overflow` 0, `count` 0.
- Reset is asynchronous assert and synchronous deassert (the reset is externally synchronized).
- `start` sampled at edge E0 → `busy` high from E0.
- Bits 0..WIDTH-1 are processed at edges E1..E_WIDTH.
- `done` is high for exactly one cycle after E_WIDTH; `busy` is low in that cycle.
- Latency from the accept edge to `done` high is WIDTH cycles.
- Throughput: back-to-back accepts are possible, one op per WIDTH+1 cycles, when `start` is held in the DONE cycle.
- Reset mid-RUN aborts the operation: no `done` pulse, and outputs return to their reset values.
- `result` and flags change only on entry to DONE.

## Structure
- Package `alu_pkg`:
  - op field positions (`INV_A`=3, `INV_B`=2, `FN` = 1:0).
  - function codes FN_AND, FN_OR, FN_ADD.
  - named op constants ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR.
  - state enum IDLE/RUN/DONE.
- Sub-module `alu_slice`: combinational 1-bit slice with inputs a, b, cin and op[3:0], outputs res and cout. It is fully defined for all op values, with no latches.
- The `count` width is $clog2(WIDTH).

## Test plan
- WIDTH=8, ADD a=0x7F, b=0x01 → `done` WIDTH cycles after accept; result 0x80, carry_out 0, overflow 1, zero 0.
- SUB a=0x05, b=0x05 → result 0x00, zero 1, carry_out 1, overflow 0. SUB a=0x00, b=0x01 → result 0xFF, carry_out 0.
- AND 0xCC, 0xAA → 0x88. OR → 0xEE. NOR 0xF0, 0x0F → 0x00 with zero 1. All logic ops give carry_out 0 and overflow 0.
- `start` pulsed at cycle 3 of RUN with different operands → ignored; the first result is intact, exactly one `done` pulse, and `busy` is continuous.
- `rst_n` low at cycle 4 of RUN → busy/done/result are 0 immediately, with no `done` pulse afterwards. A following ADD 0x10+0x20 → 0x30.
- `start` held through DONE (ADD then SUB) → second `busy` from the DONE edge, and two `done` pulses WIDTH+1 cycles apart. Reserved op 0011 → result 0, zero 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op encoding, named operations and controller states for the bit-serial ALU.
package alu_pkg;

    localparam int INV_A = 3;
    localparam int INV_B = 2;
    localparam int FN_HI = 1;
    localparam int FN_LO = 0;

    localparam logic [1:0] FN_AND = 2'b00;
    localparam logic [1:0] FN_OR  = 2'b01;
    localparam logic [1:0] FN_ADD = 2'b10;
    localparam logic [1:0] FN_RSV = 2'b11;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_add(input logic [3:0] op);
        return op[FN_HI:FN_LO] == FN_ADD;
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational 1-bit ALU slice; carry-out is only ever non-zero for the ADD function.
module alu_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [3:0] op,
    output logic       res,
    output logic       cout
);

    logic a_p;
    logic b_p;

    always_comb begin
        a_p  = a ^ op[INV_A];
        b_p  = b ^ op[INV_B];
        res  = 1'b0;
        cout = 1'b0;
        case (op[FN_HI:FN_LO])
            FN_AND: res = a_p & b_p;
            FN_OR:  res = a_p | b_p;
            FN_ADD: begin
                res  = a_p ^ b_p ^ cin;
                cout = (a_p & b_p) | (a_p & cin) | (b_p & cin);
            end
            default: res = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: feeds one operand bit pair per clock to a single slice,
// LSB first, and assembles the result word and flags at the end of the pass.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       op_q, op_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic slice_res;
    logic slice_cout;
    logic accept;

    alu_slice u_slice (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .op   (op_q),
        .res  (slice_res),
        .cout (slice_cout)
    );

    assign accept = start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        result_d = result_q;
        op_d     = op_q;
        count_d  = count_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            RUN: begin
                res_sh_d = {slice_res, res_sh_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                count_d  = count_q + CW'(1);
                if (is_add(op_q)) begin
                    carry_d = slice_cout;
                end
                // On the MSB, carry_q is the carry into bit WIDTH-1 and slice_cout the carry out.
                if (count_q == LAST) begin
                    state_d  = DONE;
                    result_d = res_sh_d;
                    zero_d   = (res_sh_d == '0);
                    cout_d   = is_add(op_q) ? slice_cout : 1'b0;
                    ovf_d    = is_add(op_q) ? (carry_q ^ slice_cout) : 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = RUN;
            a_sh_d  = a;
            b_sh_d  = b;
            op_d    = op;
            count_d = '0;
            carry_d = op[INV_B];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            result_q <= '0;
            op_q     <= '0;
            count_q  <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            result_q <= result_d;
            op_q     <= op_d;
            count_q  <= count_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl (WIDTH=8): directed cases plus random ops
// compared against a word-level arithmetic reference model.
module tb_alu_serial_ctrl;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   op    = '0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         carry_out;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .zero      (zero),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Word-level reference: invert operands, then plain AND/OR/add on whole words.
    task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic z, output logic c, output logic v);
        logic [W-1:0] xa;
        logic [W-1:0] yb;
        logic [W:0]   s;
        xa = o[3] ? ~x : x;
        yb = o[2] ? ~y : y;
        c  = 1'b0;
        v  = 1'b0;
        case (o[1:0])
            2'b00: r = xa & yb;
            2'b01: r = xa | yb;
            2'b10: begin
                s = {1'b0, xa} + {1'b0, yb} + (W+1)'(o[2]);
                r = s[W-1:0];
                c = s[W];
                v = (xa[W-1] == yb[W-1]) && (r[W-1] != xa[W-1]);
            end
            default: r = '0;
        endcase
        z = (r == '0);
    endtask

    // Called at a falling edge; start is sampled on the following rising edge.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = 4'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
        chk1("busy_after_accept", busy, 1'b1);
    endtask

    task automatic wait_done(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                             input int inject, output int done_cyc);
        logic [W-1:0] er;
        logic ez, ec, ev;
        int lat;
        int gaps;
        model(o, x, y, er, ez, ec, ev);
        lat  = 0;
        gaps = 0;
        while (done !== 1'b1 && lat < W + 4) begin
            if (busy !== 1'b1) gaps++;
            if (lat == inject) begin
                start = 1'b1;
                op    = ALU_OR;
                a     = W'($urandom);
                b     = W'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        done_cyc = cyc;
        chki($sformatf("latency op=%b a=%h b=%h", o, x, y), lat, W);
        chki("busy_continuous", gaps, 0);
        chk1("busy_low_in_done", busy, 1'b0);
        chkw($sformatf("result op=%b a=%h b=%h", o, x, y), result, er);
        chk1("zero", zero, ez);
        chk1("carry_out", carry_out, ec);
        chk1("overflow", overflow, ev);
        $display("op=%b a=%h b=%h -> result=%h z=%b c=%b v=%b (expect %h %b %b %b)",
                 o, x, y, result, zero, carry_out, overflow, er, ez, ec, ev);
    endtask

    task automatic after_done(input logic [W-1:0] held);
        @(negedge clk);
        chk1("done_one_cycle", done, 1'b0);
        chk1("idle_not_busy", busy, 1'b0);
        chkw("result_held", result, held);
    endtask

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] er;
        logic ez, ec, ev;
        int dc;
        model(o, x, y, er, ez, ec, ev);
        issue(o, x, y);
        wait_done(o, x, y, -1, dc);
        after_done(er);
    endtask

    initial begin
        logic [3:0]   named [6];
        logic [3:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int d1;
        int d2;
        int seen;

        named = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR, 4'b0011};

        @(negedge clk);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", done, 1'b0);
        chkw("reset_result", result, '0);
        chk1("reset_zero", zero, 1'b0);
        chk1("reset_carry", carry_out, 1'b0);
        chk1("reset_ovf", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(ALU_ADD, 8'h7F, 8'h01);
        run_op(ALU_SUB, 8'h05, 8'h05);
        run_op(ALU_SUB, 8'h00, 8'h01);
        run_op(ALU_AND, 8'hCC, 8'hAA);
        run_op(ALU_OR,  8'hCC, 8'hAA);
        run_op(ALU_NOR, 8'hF0, 8'h0F);
        run_op(4'b0011, 8'h5A, 8'hA5);

        // start pulsed mid-RUN must be ignored
        issue(ALU_ADD, 8'h12, 8'h34);
        wait_done(ALU_ADD, 8'h12, 8'h34, 3, d1);
        after_done(8'h46);

        // leave a non-zero result so the reset clearing it is visible
        run_op(ALU_OR, 8'h0F, 8'h30);
        issue(ALU_SUB, 8'h40, 8'h01);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk1("rst_mid_busy", busy, 1'b0);
        chk1("rst_mid_done", done, 1'b0);
        chkw("rst_mid_result", result, '0);
        chk1("rst_mid_zero", zero, 1'b0);
        chk1("rst_mid_carry", carry_out, 1'b0);
        chk1("rst_mid_ovf", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (W + 3) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chki("no_done_after_reset", seen, 0);
        run_op(ALU_ADD, 8'h10, 8'h20);

        // back-to-back: second start presented in the DONE cycle
        issue(ALU_ADD, 8'h33, 8'h44);
        wait_done(ALU_ADD, 8'h33, 8'h44, -1, d1);
        issue(ALU_SUB, 8'h33, 8'h44);
        wait_done(ALU_SUB, 8'h33, 8'h44, -1, d2);
        chki("b2b_spacing", d2 - d1, W + 1);
        after_done(8'hEF);

        for (int i = 0; i < 24; i++) begin
            ro = (i % 2 == 0) ? named[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 5 == 4) begin
                ra = W'(1) << (W - 1);
                rb = ra;
            end
            run_op(ro, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
